button_debounce: RTL and testbench

//   Input-side counterpart to the LED blink driver. Conditions one raw

---
 rtl/button_debounce.sv | 141 ++++++++++++++
 tb/tb_button_debounce.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, press/release/long-press
// pulses, debounced level and a wrapping press counter. The release pulse port is release_pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES   = 1_000_000,
   parameter int LONG_PRESS_CYCLES = 50_000_000,
   parameter bit ACTIVE_LOW        = 1'b1,
   parameter int COUNT_W           = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_raw,
   output logic               btn_level,
   output logic               press,
   output logic               release_pulse,
   output logic               long_press,
   output logic [COUNT_W-1:0] press_count
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 2);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_PEND,
      PRESSED,
      RELEASE_PEND
   } state_t;

   logic               sync1_reg, sync2_reg;
   logic               s;
   state_t             state_reg, state_next;
   logic [DB_W-1:0]    db_cnt_reg, db_cnt_next;
   logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
   logic               level_reg, level_next;
   logic               press_reg, press_next;
   logic               rel_reg, rel_next;
   logic               long_reg, long_next;
   logic [COUNT_W-1:0] count_reg, count_next;

   // Sync flops idle at the unpressed pin level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= ACTIVE_LOW;
         sync2_reg <= ACTIVE_LOW;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
      end
   end

   assign s = sync2_reg ^ ACTIVE_LOW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= RELEASED;
         db_cnt_reg   <= '0;
         hold_cnt_reg <= '0;
         level_reg    <= 1'b0;
         press_reg    <= 1'b0;
         rel_reg      <= 1'b0;
         long_reg     <= 1'b0;
         count_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         db_cnt_reg   <= db_cnt_next;
         hold_cnt_reg <= hold_cnt_next;
         level_reg    <= level_next;
         press_reg    <= press_next;
         rel_reg      <= rel_next;
         long_reg     <= long_next;
         count_reg    <= count_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      db_cnt_next   = db_cnt_reg;
      hold_cnt_next = hold_cnt_reg;
      level_next    = level_reg;
      press_next    = 1'b0;
      rel_next      = 1'b0;
      long_next     = 1'b0;
      count_next    = count_reg;

      // Hold time keeps running through a pending release so a glitch cannot delay long_press.
      if ((state_reg == PRESSED || state_reg == RELEASE_PEND) && hold_cnt_reg < HOLD_LAST) begin
         hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
         long_next     = (hold_cnt_reg == HOLD_PRE);
      end

      case (state_reg)
         RELEASED: begin
            if (s) begin
               state_next  = PRESS_PEND;
               db_cnt_next = '0;
            end
         end
         PRESS_PEND: begin
            if (!s) begin
               state_next = RELEASED;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next    = PRESSED;
               level_next    = 1'b1;
               press_next    = 1'b1;
               count_next    = count_reg + COUNT_W'(1);
               hold_cnt_next = '0;
            end else begin
               db_cnt_next = db_cnt_reg + DB_W'(1);
            end
         end
         PRESSED: begin
            if (!s) begin
               state_next  = RELEASE_PEND;
               db_cnt_next = '0;
            end
         end
         RELEASE_PEND: begin
            if (s) begin
               state_next = PRESSED;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next = RELEASED;
               level_next = 1'b0;
               rel_next   = 1'b1;
            end else begin
               db_cnt_next = db_cnt_reg + DB_W'(1);
            end
         end
         default: state_next = RELEASED;
      endcase
   end

   assign btn_level     = level_reg;
   assign press         = press_reg;
   assign release_pulse = rel_reg;
   assign long_press    = long_reg;
   assign press_count   = count_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected pulses (kind, edge, count),
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_button_debounce;

   localparam int DB = 4;
   localparam int LP = 10;
   localparam int CW = 2;

   localparam int K_PRESS = 0;
   localparam int K_LONG  = 1;
   localparam int K_REL   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_raw = 1'b1;
   logic          btn_level, press, release_pulse, long_press;
   logic [CW-1:0] press_count;

   button_debounce #(
      .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1'b1), .COUNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .press(press),
      .release_pulse(release_pulse), .long_press(long_press), .press_count(press_count)
   );

   always #5 clk = ~clk;

   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   typedef struct {
      int kind;
      int edge_at;
      int cnt;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  exp_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic push(input int kind, input int edge_at);
      ev_t ev;
      if (kind == K_PRESS) exp_count = (exp_count + 1) % (1 << CW);
      ev.kind = kind;
      ev.edge_at = edge_at;
      ev.cnt = exp_count;
      exp_q.push_back(ev);
   endtask

   task automatic check_ev(input int kind);
      ev_t ev;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_pulse: got kind %0d at edge %0d expected none", kind, edge_no);
      end else begin
         ev = exp_q.pop_front();
         chk("pulse_kind", kind, ev.kind);
         chk("pulse_edge", edge_no, ev.edge_at);
         chk("pulse_count", int'(press_count), ev.cnt);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (press)         check_ev(K_PRESS);
         if (long_press)    check_ev(K_LONG);
         if (release_pulse) check_ev(K_REL);
      end
   end

   task automatic wait_to(input int n);
      while (edge_no < n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"}, int'(btn_level), 0);
      chk({tag, "_press"}, int'(press), 0);
      chk({tag, "_release"}, int'(release_pulse), 0);
      chk({tag, "_long"}, int'(long_press), 0);
      chk({tag, "_count"}, int'(press_count), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, p;
      int wrap_exp[5];
      wrap_exp = '{1, 2, 3, 0, 1};

      // reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // clean press, long press once, then release
      e = edge_no + 1;
      push(K_PRESS, e + 6);
      push(K_LONG, e + 15);
      btn_raw = 1'b0;
      wait_to(e + 5);
      chk("t1_level_before", int'(btn_level), 0);
      wait_to(e + 6);
      chk("t1_level_after", int'(btn_level), 1);
      wait_to(e + 115);
      e = edge_no + 1;
      push(K_REL, e + 6);
      btn_raw = 1'b1;
      wait_to(e + 5);
      chk("t1_rel_level_before", int'(btn_level), 1);
      wait_to(e + 6);
      chk("t1_rel_level_after", int'(btn_level), 0);
      wait_to(e + 15);

      // bounce: 3 low, 1 high, then held low; press 4 stable cycles after last bounce
      e = edge_no + 1;
      btn_raw = 1'b0;
      wait_to(e + 2);
      btn_raw = 1'b1;
      wait_to(e + 3);
      btn_raw = 1'b0;
      p = e + 10;
      push(K_PRESS, p);
      push(K_LONG, p + 9);
      wait_to(p);
      chk("t2_level", int'(btn_level), 1);

      // 2-cycle release glitch while pressed: no release, long_press unchanged
      wait_to(p + 3);
      btn_raw = 1'b1;
      wait_to(p + 5);
      btn_raw = 1'b0;
      wait_to(p + 7);
      chk("t4_level_glitch", int'(btn_level), 1);
      wait_to(p + 20);
      chk("t4_level_after", int'(btn_level), 1);
      e = edge_no + 1;
      push(K_REL, e + 6);
      btn_raw = 1'b1;
      wait_to(e + 12);

      // reset mid PRESS_PEND, button held across deassert
      e = edge_no + 1;
      btn_raw = 1'b0;
      wait_to(e + 3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_pend");
      exp_count = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      e = edge_no + 1;
      push(K_PRESS, e + 6);
      wait_to(e + 8);
      chk("t6_level_pressed", int'(btn_level), 1);

      // reset mid PRESSED: no release pulse afterwards
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_pressed");
      exp_count = 0;
      btn_raw = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("t6_level_idle", int'(btn_level), 0);

      // wrap: 5 short press/release cycles
      for (int i = 0; i < 5; i++) begin
         e = edge_no + 1;
         push(K_PRESS, e + 6);
         btn_raw = 1'b0;
         wait_to(e + 7);
         chk("t5_count", int'(press_count), wrap_exp[i]);
         e = edge_no + 1;
         push(K_REL, e + 6);
         btn_raw = 1'b1;
         wait_to(e + 9);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
